// File: rtl/pps_slave_timestamper.sv
// Timestamps active PPS edges against local ClockTime, removing pipeline and
// cable delay, and tracks pulse period for lock, period-error and missing pulse.
module pps_slave_timestamper #(
  parameter int unsigned ClockPeriod_Gen = 20,
  parameter int unsigned InputDelay_Gen  = 0,
  parameter int unsigned PeriodNs_Gen    = 1000000000,
  parameter int unsigned PeriodTolNs_Gen = 1000
) (
  input  logic        SysClk_ClkIn,
  input  logic        SysRst_RstIn,
  input  logic [31:0] ClockTime_Second_DatIn,
  input  logic [31:0] ClockTime_Nanosecond_DatIn,
  input  logic        ClockTime_TimeJump_DatIn,
  input  logic        ClockTime_ValIn,
  input  logic        Pps_EvtIn,
  input  logic        Enable_EnaIn,
  input  logic        Polarity_DatIn,
  input  logic [15:0] CableDelay_DatIn,
  output logic [31:0] Timestamp_Second_DatOut,
  output logic [31:0] Timestamp_Nanosecond_DatOut,
  output logic        Timestamp_ValOut,
  output logic        Locked_DatOut,
  output logic        PeriodError_EvtOut,
  output logic        MissingPulse_EvtOut
);

  localparam logic [31:0] NS_PER_SEC = 32'd1000000000;
  localparam logic [31:0] PER_N      = 32'(PeriodNs_Gen / ClockPeriod_Gen);
  localparam logic [31:0] PER_T      = 32'(PeriodTolNs_Gen / ClockPeriod_Gen);
  localparam logic [31:0] PER_LO     = PER_N - PER_T;
  localparam logic [31:0] PER_HI     = PER_N + PER_T;
  localparam logic [31:0] PER_MISS   = PER_HI + 32'd1;
  // s1, s2 and the edge cycle each cost one clock before the time is captured
  localparam logic [31:0] FIXED_COMP = 32'(3 * ClockPeriod_Gen + InputDelay_Gen);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FIRST = 2'd1,
    LOCKED     = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        pps_norm;
  logic        s1_p0, s2_p1, h_p2;
  logic        edge_e;
  logic        cap_ok;
  logic [31:0] comp;
  logic [31:0] cnt, cnt_nxt, cnt_inc;
  logic [63:0] ts_comp;
  logic        vld_nxt, perr_nxt, miss_nxt;
  logic        vld_p3, perr_p3, miss_p3;
  logic [31:0] ts_sec_p3, ts_ns_p3;

  function automatic logic [63:0] compensate(input logic [31:0] sec,
                                             input logic [31:0] ns,
                                             input logic [31:0] delay);
    logic [31:0] sec_c;
    logic [31:0] ns_c;
    if (ns < delay) begin
      ns_c  = ns + NS_PER_SEC - delay;
      sec_c = sec - 32'd1;
    end else begin
      ns_c  = ns - delay;
      sec_c = sec;
    end
    return {sec_c, ns_c};
  endfunction

  assign pps_norm = Polarity_DatIn ? Pps_EvtIn : ~Pps_EvtIn;

  // Synchronizer and edge history
  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      s1_p0 <= 1'b0;
      s2_p1 <= 1'b0;
      h_p2  <= 1'b0;
    end else begin
      s1_p0 <= pps_norm;
      s2_p1 <= s1_p0;
      h_p2  <= s2_p1;
    end
  end

  // Edge cycle E: capture, period check and state update
  assign edge_e  = s2_p1 & ~h_p2;
  assign cap_ok  = ClockTime_ValIn & ~ClockTime_TimeJump_DatIn;
  assign comp    = FIXED_COMP + {16'd0, CableDelay_DatIn};
  assign ts_comp = compensate(ClockTime_Second_DatIn, ClockTime_Nanosecond_DatIn, comp);
  assign cnt_inc = (cnt == 32'hFFFF_FFFF) ? cnt : cnt + 32'd1;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_inc;
    vld_nxt   = 1'b0;
    perr_nxt  = 1'b0;
    miss_nxt  = 1'b0;
    if (!Enable_EnaIn) begin
      state_nxt = IDLE;
      cnt_nxt   = 32'd0;
    end else begin
      case (state)
        IDLE: begin
          state_nxt = WAIT_FIRST;
          cnt_nxt   = 32'd0;
        end
        WAIT_FIRST: begin
          if (edge_e) begin
            vld_nxt   = cap_ok;
            cnt_nxt   = 32'd1;
            state_nxt = LOCKED;
          end
        end
        LOCKED: begin
          // An edge coinciding with the timeout takes priority over it
          if (edge_e) begin
            vld_nxt = cap_ok;
            cnt_nxt = 32'd1;
            if ((cnt < PER_LO) || (cnt > PER_HI)) begin
              perr_nxt  = 1'b1;
              state_nxt = WAIT_FIRST;
            end
          end else if (cnt >= PER_MISS) begin
            miss_nxt  = 1'b1;
            state_nxt = WAIT_FIRST;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = 32'd0;
        end
      endcase
    end
  end

  // Output register stage
  always_ff @(posedge SysClk_ClkIn) begin
    if (SysRst_RstIn) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      vld_p3    <= 1'b0;
      perr_p3   <= 1'b0;
      miss_p3   <= 1'b0;
      ts_sec_p3 <= 32'd0;
      ts_ns_p3  <= 32'd0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      vld_p3  <= vld_nxt;
      perr_p3 <= perr_nxt;
      miss_p3 <= miss_nxt;
      if (vld_nxt) begin
        ts_sec_p3 <= ts_comp[63:32];
        ts_ns_p3  <= ts_comp[31:0];
      end
    end
  end

  assign Timestamp_Second_DatOut     = ts_sec_p3;
  assign Timestamp_Nanosecond_DatOut = ts_ns_p3;
  assign Timestamp_ValOut            = vld_p3;
  assign PeriodError_EvtOut          = perr_p3;
  assign MissingPulse_EvtOut         = miss_p3;
  assign Locked_DatOut               = (state == LOCKED);

endmodule

// File: tb/tb_pps_slave_timestamper.sv
// Randomized PPS stimulus checked every cycle against a cycle-indexed model of
// edge times, period rules and timestamp arithmetic.
module tb_pps_slave_timestamper;

  logic        clk = 1'b0;
  logic        rst, jump, val, pps, ena, pol;
  logic [31:0] ct_sec, ct_ns;
  logic [15:0] cable;
  logic [31:0] ts_sec, ts_ns;
  logic        ts_val, locked, perr, miss;

  always #5 clk = ~clk;

  pps_slave_timestamper #(
    .ClockPeriod_Gen(20),
    .InputDelay_Gen(0),
    .PeriodNs_Gen(1000),
    .PeriodTolNs_Gen(40)
  ) dut (
    .SysClk_ClkIn(clk),
    .SysRst_RstIn(rst),
    .ClockTime_Second_DatIn(ct_sec),
    .ClockTime_Nanosecond_DatIn(ct_ns),
    .ClockTime_TimeJump_DatIn(jump),
    .ClockTime_ValIn(val),
    .Pps_EvtIn(pps),
    .Enable_EnaIn(ena),
    .Polarity_DatIn(pol),
    .CableDelay_DatIn(cable),
    .Timestamp_Second_DatOut(ts_sec),
    .Timestamp_Nanosecond_DatOut(ts_ns),
    .Timestamp_ValOut(ts_val),
    .Locked_DatOut(locked),
    .PeriodError_EvtOut(perr),
    .MissingPulse_EvtOut(miss)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: normalized input sampled at each clock edge, edge times by cycle index
  bit          hist[$];
  longint      cyc = 0;
  longint      last_edge = 0;
  int          mode = 0;  // 0 disabled, 1 searching, 2 locked
  logic [31:0] exp_sec = 32'd0, exp_ns = 32'd0;
  logic        exp_val = 1'b0, exp_locked = 1'b0, exp_perr = 1'b0, exp_miss = 1'b0;

  task automatic model_step();
    bit     edge_now;
    longint sp;
    longint total;
    exp_val  = 1'b0;
    exp_perr = 1'b0;
    exp_miss = 1'b0;
    cyc++;
    // an input change sampled at edge q becomes a detected edge at edge q+2
    edge_now = hist[hist.size()-2] && !hist[hist.size()-3];
    if (rst) begin
      mode    = 0;
      exp_sec = 32'd0;
      exp_ns  = 32'd0;
      repeat (3) hist.push_back(1'b0);
    end else begin
      hist.push_back(pol ? pps : !pps);
      if (!ena) mode = 0;
      else if (mode == 0) mode = 1;
      else if (edge_now) begin
        sp = cyc - last_edge;
        last_edge = cyc;
        if (val && !jump) begin
          exp_val = 1'b1;
          total = (longint'(ct_sec) + 64'sd4294967296) * 64'sd1000000000
                  + longint'(ct_ns) - longint'(60 + int'(cable));
          exp_sec = 32'(total / 64'sd1000000000);
          exp_ns  = 32'(total % 64'sd1000000000);
        end
        if (mode == 2 && (sp < 48 || sp > 52)) begin
          exp_perr = 1'b1;
          mode = 1;
        end else mode = 2;
      end else if (mode == 2 && (cyc - last_edge) == 53) begin
        exp_miss = 1'b1;
        mode = 1;
      end
    end
    exp_locked = (mode == 2);
    while (hist.size() > 8) void'(hist.pop_front());
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    vectors++;
    assert ({ts_val, locked, perr, miss} === {exp_val, exp_locked, exp_perr, exp_miss})
    else begin
      miscompares++;
      $error("FAIL flags(val,lock,perr,miss) cyc=%0d observed=%b expected=%b", cyc,
             {ts_val, locked, perr, miss}, {exp_val, exp_locked, exp_perr, exp_miss});
    end
    vectors++;
    assert ({ts_sec, ts_ns} === {exp_sec, exp_ns})
    else begin
      miscompares++;
      $error("FAIL timestamp cyc=%0d observed=%0d.%0d expected=%0d.%0d", cyc,
             ts_sec, ts_ns, exp_sec, exp_ns);
    end
    if (ct_ns >= 32'd999999980) begin
      ct_ns  = ct_ns - 32'd999999980;
      ct_sec = ct_sec + 32'd1;
    end else ct_ns = ct_ns + 32'd20;
  endtask

  task automatic pulse(input int spacing);
    pps = pol;
    repeat (4) tick();
    pps = !pol;
    repeat (spacing - 4) tick();
  endtask

  // Edge with a chosen ClockTime/cable delay in the capture cycle
  task automatic edge_at(input logic [31:0] sec, input logic [31:0] ns, input logic [15:0] cab);
    pps = pol;
    tick();
    tick();
    ct_sec = sec;
    ct_ns  = ns;
    cable  = cab;
    tick();
  endtask

  initial begin
    repeat (3) hist.push_back(1'b0);
    rst = 1'b1; ena = 1'b0; pol = 1'b1; pps = 1'b0; val = 1'b1; jump = 1'b0;
    cable = 16'd0; ct_sec = 32'd5; ct_ns = 32'd500000;

    // reset state
    repeat (3) tick();
    rst = 1'b0;
    ena = 1'b1;
    repeat (3) tick();

    // nominal lock, then tolerance edges
    ct_sec = 32'd5; ct_ns = 32'd500000;
    repeat (4) pulse(50);
    pulse(52);
    pulse(50);
    pulse(47);
    pulse(50);
    pulse(50);
    pulse(53);
    repeat (3) pulse(50);

    // randomized spacing, cable delay and time validity
    ct_sec = $urandom;
    ct_ns  = $urandom_range(0, 999999999);
    for (int i = 0; i < 16; i++) begin
      cable = 16'($urandom_range(0, 3000));
      val   = ($urandom_range(0, 5) != 0);
      jump  = ($urandom_range(0, 7) == 0);
      pulse(int'($urandom_range(46, 54)));
    end
    val = 1'b1; jump = 1'b0;

    // missing pulse after lock
    repeat (3) pulse(50);
    repeat (60) tick();

    // borrow and second wrap
    edge_at(32'd7, 32'd30, 16'd100);
    vectors++;
    assert ({ts_val, ts_sec, ts_ns} === {1'b1, 32'd6, 32'd999999870})
    else begin
      miscompares++;
      $error("FAIL borrow observed=%b %0d.%0d expected=1 6.999999870", ts_val, ts_sec, ts_ns);
    end
    pps = 1'b0;
    repeat (20) tick();
    edge_at(32'd0, 32'd10, 16'd50);
    vectors++;
    assert ({ts_val, ts_sec, ts_ns} === {1'b1, 32'hFFFF_FFFF, 32'd999999900})
    else begin
      miscompares++;
      $error("FAIL wrap observed=%b %h.%0d expected=1 ffffffff.999999900", ts_val, ts_sec, ts_ns);
    end
    pps = 1'b0;
    repeat (20) tick();

    // invalid time while locked
    cable = 16'd0;
    repeat (3) pulse(50);
    val = 1'b0;
    pulse(50);
    val = 1'b1;
    repeat (2) pulse(50);

    // falling-edge polarity
    ena = 1'b0;
    tick();
    pol = 1'b0;
    pps = 1'b1;
    repeat (5) tick();
    ena = 1'b1;
    repeat (5) pulse(50);

    // reset in the capture cycle
    pps = pol;
    tick();
    tick();
    rst = 1'b1;
    tick();
    vectors++;
    assert ({ts_val, locked, perr, miss, ts_sec, ts_ns} === 68'd0)
    else begin
      miscompares++;
      $error("FAIL reset_in_e observed=%b %0d.%0d expected all zero",
             {ts_val, locked, perr, miss}, ts_sec, ts_ns);
    end
    rst = 1'b0;
    pps = !pol;
    repeat (10) tick();
    repeat (3) pulse(50);

    // disabled: edges ignored
    ena = 1'b0;
    repeat (3) pulse(50);
    vectors++;
    assert (locked === 1'b0)
    else begin
      miscompares++;
      $error("FAIL disabled_lock observed=%b expected=0", locked);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pps_slave_timestamper.md
# pps_slave_timestamper

Receive side of the PPS path. The block samples an external PPS input asynchronously and timestamps each active edge against the local ClockTime. It removes the input pipeline and cable delay from each timestamp, and checks the pulse period for lock, period-error and missing-pulse conditions. It sits between the board PPS input pin and the time/offset adjustment logic that consumes the timestamps.

## Interface
- ClockPeriod_Gen, 20: SysClk period in ns; integer divisor of PeriodNs_Gen and PeriodTolNs_Gen.
- InputDelay_Gen, 0: fixed board/input-buffer delay in ns, added to the compensation.
- PeriodNs_Gen, 1000000000: nominal PPS period in ns.
- PeriodTolNs_Gen, 1000: allowed period deviation in ns, ± around nominal.

Ports:
- SysClk_ClkIn  in  1  system clock; only clock.
- SysRst_RstIn  in  1  synchronous, active-high reset.
- ClockTime_Second_DatIn  in  32  local time, seconds.
- ClockTime_Nanosecond_DatIn  in  32  local time, ns, range 0..999999999.
- ClockTime_TimeJump_DatIn  in  1  local time jumped this cycle.
- ClockTime_ValIn  in  1  local time valid.
- Pps_EvtIn  in  1  asynchronous PPS input.
- Enable_EnaIn  in  1  block enable, level.
- Polarity_DatIn  in  1  1 = rising edge active, 0 = falling edge active.
- CableDelay_DatIn  in  16  cable delay in ns.
- Timestamp_Second_DatOut  out  32  compensated edge time, seconds.
- Timestamp_Nanosecond_DatOut  out  32  compensated edge time, ns.
- Timestamp_ValOut  out  1  one-cycle strobe; timestamp outputs are new.
- Locked_DatOut  out  1  high in LOCKED.
- PeriodError_EvtOut  out  1  one-cycle strobe; edge arrived outside tolerance.
- MissingPulse_EvtOut  out  1  one-cycle strobe; no edge arrived within nominal + tolerance.

## Operation
- Input path: Pps_EvtIn passes through two synchronizer flops (s1, s2), then a history flop h.
  - Polarity_DatIn = 0: the normalized signal is inverted.
  - Edge condition: s2 & ~h on the normalized signal, evaluated in cycle E.
- Compensation: comp = 3*ClockPeriod_Gen + InputDelay_Gen + CableDelay_DatIn, computed as a 32-bit unsigned value.
- Capture: in cycle E, ns_c = ClockTime_Nanosecond_DatIn − comp.
  - If ClockTime_Nanosecond_DatIn < comp, borrow: ns_c = ClockTime_Nanosecond_DatIn + 1000000000 − comp, and second_c = ClockTime_Second_DatIn − 1. Seconds wrap modulo 2^32.
  - comp ≥ 10^9 is not supported.
- Capture is suppressed when ClockTime_ValIn = 0 or ClockTime_TimeJump_DatIn = 1 in cycle E.
  - No strobe is issued and the outputs hold their previous value.
  - The period check still uses the edge, as below.
- Period counter: 32 bits, counts SysClk cycles since the last edge, saturates at all-ones.
  - N = PeriodNs_Gen/ClockPeriod_Gen; T = PeriodTolNs_Gen/ClockPeriod_Gen.
  - On each edge the counter reloads to 1.
- State machine:
  - IDLE: entered on reset or when Enable_EnaIn = 0 (from any state). Counter is held at 0; edges are ignored. Goes to WAIT_FIRST when Enable_EnaIn = 1.
  - WAIT_FIRST: first edge → timestamp, counter reloads, go to LOCKED. No timeout applies in this state.
  - LOCKED, edge arrives with counter in [N−T, N+T]: timestamp, stay in LOCKED.
  - LOCKED, edge arrives with counter < N−T: PeriodError_EvtOut strobes, timestamp still issued, go to WAIT_FIRST with counter reloaded.
  - LOCKED, counter reaches N+T+1 with no edge: MissingPulse_EvtOut strobes, go to WAIT_FIRST.
  - LOCKED, edge in the same cycle the counter hits N+T+1: the edge wins. Treated as in tolerance only if counter ≤ N+T; otherwise it is a PeriodError, with no MissingPulse.
- ClockTime_TimeJump_DatIn has no effect on the period counter.
- Polarity_DatIn change: h is updated on the same edge, so a polarity toggle can produce at most one spurious edge. Software must disable the block around polarity changes.

## Timing
- Reset values: all outputs 0; state IDLE; s1, s2 and h cleared to 0 of the normalized level.
- Latency: Pps_EvtIn transition → Timestamp_ValOut is 4 SysClk cycles.
  - Breakdown: up to 1 cycle metastability window, s1, s2, E, then the output register.
  - The 3*ClockPeriod_Gen term in comp covers s1/s2/E. The output register stage is not compensated because the time is captured in cycle E.
- Timestamp_ValOut, PeriodError_EvtOut and MissingPulse_EvtOut are one-cycle strobes, registered, asserted in cycle E+1.
- Locked_DatOut changes in cycle E+1.
- Reset asserted mid-operation: the next cycle shows the reset values. Strobes pending from cycle E are dropped.
- Minimum edge spacing: 2 cycles after synchronization. Closer input pulses are filtered by the synchronizer.

## Test plan
- Bench parameters for all scenarios: ClockPeriod_Gen = 20, PeriodNs_Gen = 1000 (N = 50), PeriodTolNs_Gen = 40 (T = 2).
- Nominal: ClockTime = {5, 500000}, CableDelay_DatIn = 0, rising edge → strobe 4 cycles later with {5, 500000 − 60 + 20*δ}, where δ is the ClockTime advance from edge to E. Subsequent edges every 50 cycles → Locked_DatOut = 1, no error strobes.
- Borrow: ClockTime ns in cycle E = 30, CableDelay_DatIn = 100 → timestamp ns = 999999870, second decremented by 1. Second = 0 → wraps to 0xFFFFFFFF.
- Period error: edges at spacing 50, then 47 → PeriodError_EvtOut strobes, state WAIT_FIRST, Locked_DatOut = 0, timestamp still issued. Spacing 52 → no error.
- Missing pulse: stop the PPS after lock → MissingPulse_EvtOut strobes exactly 53 cycles after the last edge; Locked_DatOut = 0 on the next cycle.
- Invalid time: ClockTime_ValIn = 0 in cycle E → no Timestamp_ValOut, Locked_DatOut still set. Polarity_DatIn = 0 → falling edges are timestamped.
- Reset/enable: assert SysRst_RstIn in cycle E → no strobe, all outputs 0. Enable_EnaIn = 0 → edges ignored.
